muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage. Accepts one op and runs
//   iterative shift-add multiply or restoring divide. Holds busy to stall the pipeline.
//   Delivers a 64-bit {hi,lo} result with a one-cycle write strobe to the $hi/$lo registers.
// PARAMETERS
//   XLEN      32   operand width; prod is 2*XLEN
//   ITER_CNT  32   iteration cycles per op; must equal XLEN
// PORTS
//   clock     in   1       rising-edge clock
//   reset     in   1       asynchronous, active-low reset
//   start     in   1       request; sampled only while idle or done
//   op        in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush     in   1       abort the current op (pipeline flush)
//   src_a     in   XLEN    multiplicand / dividend (rs)
//   src_b     in   XLEN    multiplier / divisor (rt)
//   busy      out  1       op in flight; pipeline stalls while high
//   done      out  1       one-cycle pulse; prod is valid
//   hilo_we   out  1       write strobe to $hi/$lo; equals done
//   prod      out  2*XLEN  [63:32] -> $hi, [31:0] -> $lo
// BEHAVIOUR
//   Reset (reset low, asynchronous): state=IDLE; busy=0; done=0; hilo_we=0; prod=0.
//   FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE, or DONE -> CALC on back-to-back.
//   IDLE/DONE + start & !flush: latch op and operands; take abs values for signed ops;
//     record the result signs; counter=0; go to CALC; busy=1 from the next cycle.
//   CALC: perform one mul or div step per cycle; at counter==ITER_CNT-1 go to FIX.
//   FIX: apply sign correction; register prod; go to DONE.
//   DONE: done=hilo_we=1 for exactly one cycle; busy=0 in this cycle.
//   Latency: start in cycle 0 -> done in cycle ITER_CNT+2 (34). One op in flight at a time.
//   start while busy: ignored, with no queuing.
//   Mult: prod = full 64-bit product (signed or unsigned per op).
//   Div: prod = {remainder, quotient}.
//     Quotient truncates toward zero. Remainder takes the sign of the dividend.
//   Divide by zero (any div op): quotient = 32'hFFFF_FFFF; remainder = src_a.
//   DIV of 32'h8000_0000 by -1: quotient = 32'h8000_0000; remainder = 0.
//   flush in CALC or FIX: go to IDLE next edge; busy=0; no done or hilo_we.
//   flush in DONE: done and hilo_we are still asserted (result already committed).
//   flush with start in the same cycle: flush wins; start is dropped.
//   reset low mid-op: immediate IDLE; partial result is discarded; no strobe.
//   prod holds its last value until the next FIX.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined:
//     MULT/MULTU use a single combinational XLEN x XLEN multiply: IDLE -> FIX -> DONE.
//     done is asserted in cycle 2 after start.
//     Divide is unchanged, including its latency.
//   MULDIV_FAST_MUL_EN not defined:
//     Multiply is iterative with the same 34-cycle latency as divide.
// STRUCTURE
//   muldiv_pkg: op encodings (OP_MULT..OP_DIVU); FSM state encodings; XLEN default;
//     divide-by-zero quotient constant.
//   Sub-module muldiv_step: combinational single-iteration datapath.
//     Inputs: acc, operand, and mode (mul or div).
//     Outputs: next acc and next operand.
//     The FSM, counter and sign-fix logic stay in muldiv_sequencer.
// TESTING
//   MULT -3 x 5: prod=64'hFFFF_FFFF_FFFF_FFF1; done in cycle 34; busy high in cycles 1..33.
//   DIVU 100/7: prod={32'h2, 32'hE}.
//     DIV -7/2: prod={32'hFFFF_FFFF, 32'hFFFF_FFFD}.
//   DIVU 9/0: prod={32'h9, 32'hFFFF_FFFF}.
//     DIV 32'h8000_0000 / -1: prod={32'h0, 32'h8000_0000}.
//   flush at cycle 10 of a DIV: busy=0 in cycle 11; no done or hilo_we; prod unchanged.
//   start held in the DONE cycle: second op accepted back-to-back; its done comes 34 cycles later.
//     start asserted mid-CALC is ignored.
//   reset low at cycle 5 of a MULTU: outputs go to 0 at once.
//     After release, a fresh MULTU 32'hFFFF_FFFF x 2 gives prod=64'h1_FFFF_FFFE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states,
// step-datapath modes and the divide-by-zero quotient.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [1:0] op);
    op_dec_t d;
    d.is_div    = 1'b0;
    d.is_signed = 1'b0;
    case (op)
      OP_MULT:  d.is_signed = 1'b1;
      OP_MULTU: d.is_signed = 1'b0;
      OP_DIV: begin
        d.is_div    = 1'b1;
        d.is_signed = 1'b1;
      end
      OP_DIVU:  d.is_div = 1'b1;
      default:  d.is_div = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and the mul/div
// sequencer (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic              start;
  logic [1:0]        op;
  logic              flush;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic              busy;
  logic              done;
  logic              hilo_we;
  logic [2*XLEN-1:0] prod;

  modport master (
    output start, op, flush, src_a, src_b,
    input  busy, done, hilo_we, prod
  );

  modport slave (
    input  start, op, flush, src_a, src_b,
    output busy, done, hilo_we, prod
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide. The pair
// {acc, operand} is the working register; addend is the multiplicand/divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            mode_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic [XLEN-1:0] addend_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] operand_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The extra top bit carries the add-out (multiply) or the borrow (divide).
  always_comb begin
    sum       = {1'b0, acc_i} + (operand_i[0] ? {1'b0, addend_i} : '0);
    shifted   = {acc_i, operand_i[XLEN-1]};
    diff      = shifted - {1'b0, addend_i};
    acc_o     = acc_i;
    operand_o = operand_i;
    if (mode_i == MODE_DIV) begin
      if (!diff[XLEN]) begin
        acc_o     = diff[XLEN-1:0];
        operand_o = {operand_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o     = shifted[XLEN-1:0];
        operand_o = {operand_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o     = sum[XLEN:1];
      operand_o = {sum[0], operand_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing {hi,lo}. Defining
// MULDIV_FAST_MUL_EN replaces the iterative multiply with a one-shot multiplier.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ITER_CNT = XLEN
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(ITER_CNT);
  localparam logic [CW-1:0] LastCnt = CW'(ITER_CNT - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   addend_q, addend_d;
  logic [XLEN-1:0]   srca_q, srca_d;
  logic              div_q, div_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              divzero_q, divzero_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  op_dec_t           dec;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN-1:0]   step_acc, step_opnd;
  logic [2*XLEN-1:0] mag, mul_res, div_res;
  logic [XLEN-1:0]   quot, rem;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i    (div_q ? MODE_DIV : MODE_MUL),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .addend_i  (addend_q),
    .acc_o     (step_acc),
    .operand_o (step_opnd)
  );

  always_comb begin
    dec   = decode_op(bus.op);
    a_neg = dec.is_signed & bus.src_a[XLEN-1];
    b_neg = dec.is_signed & bus.src_b[XLEN-1];
    abs_a = a_neg ? -bus.src_a : bus.src_a;
    abs_b = b_neg ? -bus.src_b : bus.src_b;
  end

  // Magnitude result is sign-corrected here; div-by-zero bypasses the datapath.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    if (div_q) begin
      mag = {acc_q, opnd_q};
    end else begin
      mag = {{XLEN{1'b0}}, addend_q} * {{XLEN{1'b0}}, opnd_q};
    end
`else
    mag = {acc_q, opnd_q};
`endif
    mul_res = (sign_a_q ^ sign_b_q) ? -mag : mag;
    quot    = (sign_a_q ^ sign_b_q) ? -opnd_q : opnd_q;
    rem     = sign_a_q ? -acc_q : acc_q;
    div_res = divzero_q ? {srca_q, XLEN'(DIV0_QUOT)} : {rem, quot};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    addend_d  = addend_q;
    srca_d    = srca_q;
    div_d     = div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    divzero_d = divzero_q;
    prod_d    = prod_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && !bus.flush) begin
          div_d     = dec.is_div;
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          divzero_d = dec.is_div && (bus.src_b == '0);
          srca_d    = bus.src_a;
          acc_d     = '0;
          cnt_d     = '0;
          if (dec.is_div) begin
            opnd_d   = abs_a;
            addend_d = abs_b;
          end else begin
            opnd_d   = abs_b;
            addend_d = abs_a;
          end
`ifdef MULDIV_FAST_MUL_EN
          state_d = dec.is_div ? ST_CALC : ST_FIX;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = step_acc;
          opnd_d = step_opnd;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          prod_d  = div_q ? div_res : mul_res;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      addend_q  <= '0;
      srca_q    <= '0;
      div_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divzero_q <= 1'b0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      addend_q  <= addend_d;
      srca_q    <= srca_d;
      div_q     <= div_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      divzero_q <= divzero_d;
      prod_q    <= prod_d;
    end
  end

  assign bus.busy    = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.hilo_we = (state_q == ST_DONE);
  assign bus.prod    = prod_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: table of ops with hand-computed
// {hi,lo} results plus flush, back-to-back and mid-op reset sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expProd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] lastExp;
  vec_t vecs[12];

  muldiv_if #(.XLEN(XLEN)) busIf ();

  muldiv_sequencer #(.XLEN(XLEN), .ITER_CNT(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    busIf.start = start;
    busIf.op    = op;
    busIf.src_a = a;
    busIf.src_b = b;
  endtask

  // Starts an op and measures start-to-done latency in cycles.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expProd, input int expLat);
    int   cyc;
    logic busyBad;
    @(negedge clock);
    applyStimulus(1'b1, op, a, b);
    @(negedge clock);
    busIf.start = 1'b0;
    cyc = 1;
    busyBad = 1'b0;
    while (!busIf.done && cyc < 100) begin
      if (!busIf.busy) busyBad = 1'b1;
      @(negedge clock);
      cyc++;
    end
    checkOutput({name, "_done"}, 64'(busIf.done), 64'd1);
    checkOutput({name, "_lat"}, 64'(cyc), 64'(expLat));
    checkOutput({name, "_busyrun"}, 64'(busyBad), 64'd0);
    checkOutput({name, "_prod"}, busIf.prod, expProd);
    checkOutput({name, "_we"}, 64'(busIf.hilo_we), 64'd1);
    checkOutput({name, "_busydone"}, 64'(busIf.busy), 64'd0);
    lastExp = expProd;
  endtask

  initial begin
    int   cyc;
    logic seen;

    vecs[0]  = '{"mult_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1]  = '{"multu_max2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE};
    vecs[2]  = '{"mult_7xm6",   OP_MULT,  32'd7,         32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[3]  = '{"multu_maxsq", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{"mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[5]  = '{"divu_100_7",  OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[6]  = '{"div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    vecs[7]  = '{"div_7_m2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[8]  = '{"divu_9_0",    OP_DIVU,  32'd9,         32'd0,         64'h0000_0009_FFFF_FFFF};
    vecs[9]  = '{"div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[10] = '{"div_m5_0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF};
    vecs[11] = '{"divu_max_16", OP_DIVU,  32'hFFFF_FFFF, 32'd16,        64'h0000_000F_0FFF_FFFF};

    applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0);
    busIf.flush = 1'b0;
    lastExp = '0;

    repeat (2) @(negedge clock);
    checkOutput("rst_busy", 64'(busIf.busy), 64'd0);
    checkOutput("rst_done", 64'(busIf.done), 64'd0);
    checkOutput("rst_we", 64'(busIf.hilo_we), 64'd0);
    checkOutput("rst_prod", busIf.prod, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expProd,
            vecs[i].op[1] ? DivLat : MulLat);
    end

    // Flush at cycle 10 of a DIV: no strobe, prod keeps the previous result.
    @(negedge clock);
    applyStimulus(1'b1, OP_DIV, 32'd1000, 32'd3);
    @(negedge clock);
    busIf.start = 1'b0;
    repeat (9) @(negedge clock);
    checkOutput("flush_busy10", 64'(busIf.busy), 64'd1);
    busIf.flush = 1'b1;
    @(negedge clock);
    busIf.flush = 1'b0;
    checkOutput("flush_busy11", 64'(busIf.busy), 64'd0);
    checkOutput("flush_prod", busIf.prod, lastExp);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busIf.done || busIf.hilo_we) seen = 1'b1;
    end
    checkOutput("flush_nodone", 64'(seen), 64'd0);

    // Back-to-back: second op started in the first op's DONE cycle;
    // a start raised mid-CALC with other operands must be ignored.
    runOp("b2b_first", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DivLat);
    applyStimulus(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    cyc = 0;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clock);
      cyc++;
      if (cyc == 5) applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd3);
      else busIf.start = 1'b0;
      if (busIf.done) seen = 1'b1;
    end
    checkOutput("b2b_done", 64'(seen), 64'd1);
    checkOutput("b2b_lat", 64'(cyc), 64'(DivLat));
    checkOutput("b2b_prod", busIf.prod, 64'hFFFF_FFFF_FFFF_FFFD);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busIf.done) seen = 1'b1;
    end
    checkOutput("midcalc_ignored", 64'(seen), 64'd0);

    // Flush together with start in DONE: strobe stays, new op is dropped.
    runOp("fdone_op", OP_MULTU, 32'd6, 32'd7, 64'd42, MulLat);
    applyStimulus(1'b1, OP_MULTU, 32'd2, 32'd2);
    busIf.flush = 1'b1;
    #1;
    checkOutput("fdone_done", 64'(busIf.done), 64'd1);
    checkOutput("fdone_we", 64'(busIf.hilo_we), 64'd1);
    @(negedge clock);
    busIf.start = 1'b0;
    busIf.flush = 1'b0;
    checkOutput("fdone_busy", 64'(busIf.busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busIf.done) seen = 1'b1;
    end
    checkOutput("fdone_dropped", 64'(seen), 64'd0);
    checkOutput("fdone_prod", busIf.prod, 64'd42);

    // Asynchronous reset at cycle 5 of a MULTU.
    @(negedge clock);
    applyStimulus(1'b1, OP_MULTU, 32'd5, 32'd7);
    @(negedge clock);
    busIf.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busIf.busy), 64'd0);
    checkOutput("arst_done", 64'(busIf.done), 64'd0);
    checkOutput("arst_we", 64'(busIf.hilo_we), 64'd0);
    checkOutput("arst_prod", busIf.prod, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    runOp("arst_fresh", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, MulLat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
